// File: rtl/mux_pkg.sv
// Shared types and constants for the 4-channel stream demultiplexer.
package mux_pkg;

   localparam int NUM_CH = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic [1:0] {
      CH_A = 2'd0,
      CH_B = 2'd1,
      CH_C = 2'd2,
      CH_D = 2'd3
   } ch_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry registered holding slot for a single output channel.
// Load wins over consume, so a beat can leave and a new beat can arrive
// in the same cycle, which keeps the channel at one beat per cycle.
module demux_slot #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_consume,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_vld
);

   logic [WIDTH-1:0] data_reg, data_next;
   logic             vld_reg, vld_next;

   // Next-state: load takes priority; consume alone only clears valid
   always_comb begin
      data_next = data_reg;
      vld_next  = vld_reg;
      if (i_load) begin
         data_next = i_data;
         vld_next  = 1'b1;
      end else if (i_consume) begin
         vld_next  = 1'b0;
      end
   end

   // Slot registers, cleared immediately by reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         data_reg <= '0;
         vld_reg  <= 1'b0;
      end else begin
         data_reg <= data_next;
         vld_reg  <= vld_next;
      end
   end

   assign o_data = data_reg;
   assign o_vld  = vld_reg;

endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a holding slot per channel.
// Optional per-channel accepted-beat counters are built when DEMUX4_CNT_EN
// is defined; without it the o_cnt port and counters do not exist.
module demux4_stream
   import mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [WIDTH-1:0]        i_data,
   input  logic [1:0]              i_sel,
   input  logic                    i_valid,
   output logic                    o_ready,
   output logic [WIDTH-1:0]        o_a,
   output logic [WIDTH-1:0]        o_b,
   output logic [WIDTH-1:0]        o_c,
   output logic [WIDTH-1:0]        o_d,
   output logic [NUM_CH-1:0]       o_vld,
   input  logic [NUM_CH-1:0]       i_rdy
`ifdef DEMUX4_CNT_EN
   ,
   output logic [NUM_CH*CNT_W-1:0] o_cnt
`endif
);

   logic [WIDTH-1:0]  slot_data [NUM_CH];
   logic [NUM_CH-1:0] slot_vld;
   logic [NUM_CH-1:0] load;
   logic [NUM_CH-1:0] consume;
   logic              accept;
   sel_t              sel;

   assign sel = i_sel;

   // The addressed slot can take a beat if empty or draining this cycle;
   // held low during reset so nothing appears accepted.
   assign o_ready = i_rst_n && (!slot_vld[sel] || i_rdy[sel]);
   assign accept  = i_valid && o_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign load[gi]    = accept && (sel == sel_t'(gi));
         assign consume[gi] = slot_vld[gi] && i_rdy[gi];

         demux_slot #(.WIDTH(WIDTH)) u_slot (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_load    (load[gi]),
            .i_consume (consume[gi]),
            .i_data    (i_data),
            .o_data    (slot_data[gi]),
            .o_vld     (slot_vld[gi])
         );

`ifdef DEMUX4_CNT_EN
         logic [CNT_W-1:0] cnt_reg;

         // Count accepts to this channel, wrapping naturally at 2^CNT_W
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               cnt_reg <= '0;
            end else if (load[gi]) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end

         assign o_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
`endif
      end
   endgenerate

   assign o_a   = slot_data[CH_A];
   assign o_b   = slot_data[CH_B];
   assign o_c   = slot_data[CH_C];
   assign o_d   = slot_data[CH_D];
   assign o_vld = slot_vld;

endmodule

// File: tb/tb_demux4_stream.sv
// Directed self-checking bench for demux4_stream.
// Counter checks are compiled in only when DEMUX4_CNT_EN is defined.
module tb_demux4_stream;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] data;
   logic [1:0]       sel;
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] a, b, c, d;
   logic [3:0]       vld;
   logic [3:0]       rdy;
`ifdef DEMUX4_CNT_EN
   logic [4*CNT_W-1:0] cnt;
`endif

   int checks = 0;
   int errors = 0;

   demux4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_data  (data),
      .i_sel   (sel),
      .i_valid (valid),
      .o_ready (ready),
      .o_a     (a),
      .o_b     (b),
      .o_c     (c),
      .o_d     (d),
      .o_vld   (vld),
      .i_rdy   (rdy)
`ifdef DEMUX4_CNT_EN
      ,
      .o_cnt   (cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-12s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] dt);
      valid = v;
      sel   = s;
      data  = dt;
   endtask

   initial begin
      rst_n = 1'b0;
      rdy   = 4'b1111;
      drive(1'b0, 2'd0, 8'h00);
      step();
      step();

      // Reset state
      chk("rst_vld", {28'd0, vld}, 32'h0);
      chk("rst_ready", {31'd0, ready}, 32'h0);
      chk("rst_a", {24'd0, a}, 32'h0);

      // Routing, back-to-back, first beat right after release
      rst_n = 1'b1;
      drive(1'b1, 2'd0, 8'd1);
      #1;
      chk("route_rdy", {31'd0, ready}, 32'h1);
      step();
      chk("route_vld0", {28'd0, vld}, 32'h1);
      chk("route_a", {24'd0, a}, 32'd1);
      drive(1'b1, 2'd1, 8'd2);
      step();
      chk("route_vld1", {28'd0, vld}, 32'h2);
      chk("route_b", {24'd0, b}, 32'd2);
      drive(1'b1, 2'd2, 8'd3);
      step();
      chk("route_vld2", {28'd0, vld}, 32'h4);
      chk("route_c", {24'd0, c}, 32'd3);
      drive(1'b1, 2'd3, 8'd4);
      step();
      chk("route_vld3", {28'd0, vld}, 32'h8);
      chk("route_d", {24'd0, d}, 32'd4);
      drive(1'b0, 2'd0, 8'd0);
      step();
      chk("route_idle", {28'd0, vld}, 32'h0);

      // Isolation: channel c stalled
      rdy = 4'b1011;
      drive(1'b1, 2'd2, 8'd3);
      step();
      chk("iso_vld", {28'd0, vld}, 32'h4);
      chk("iso_c3", {24'd0, c}, 32'd3);
      drive(1'b1, 2'd2, 8'd5);
      #1;
      chk("iso_rdy_c", {31'd0, ready}, 32'h0);
      step();
      chk("iso_c_hold", {24'd0, c}, 32'd3);
      drive(1'b1, 2'd0, 8'd7);
      #1;
      chk("iso_rdy_a", {31'd0, ready}, 32'h1);
      step();
      chk("iso_a7", {24'd0, a}, 32'd7);
      chk("iso_vld2", {28'd0, vld}, 32'h5);
      rdy = 4'b1111;
      drive(1'b1, 2'd2, 8'd5);
      #1;
      chk("iso_rdy_c2", {31'd0, ready}, 32'h1);
      step();
      chk("iso_c5", {24'd0, c}, 32'd5);
      chk("iso_vld3", {28'd0, vld}, 32'h4);
      drive(1'b0, 2'd0, 8'd0);
      step();
      chk("iso_idle", {28'd0, vld}, 32'h0);

      // Throughput: 8 beats to b with no bubble
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 2'd1, 8'(10 + i));
         #1;
         chk("thr_rdy", {31'd0, ready}, 32'h1);
         step();
         chk("thr_b", {24'd0, b}, 32'(10 + i));
         chk("thr_vld", {31'd0, vld[1]}, 32'h1);
      end
      drive(1'b0, 2'd0, 8'd0);
      step();
      chk("thr_idle", {28'd0, vld}, 32'h0);

      // Stall hold on channel a
      rdy = 4'b1110;
      drive(1'b1, 2'd0, 8'hAA);
      step();
      drive(1'b0, 2'd0, 8'h00);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_a", {24'd0, a}, 32'hAA);
         chk("stall_vld", {31'd0, vld[0]}, 32'h1);
      end
      rdy = 4'b1111;
      step();
      chk("stall_drain", {28'd0, vld}, 32'h0);

      // Reset mid-run with b and d full
      rdy = 4'b0000;
      drive(1'b1, 2'd1, 8'h22);
      step();
      drive(1'b1, 2'd3, 8'h44);
      step();
      drive(1'b0, 2'd0, 8'h00);
      chk("mid_full", {28'd0, vld}, 32'hA);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_vld", {28'd0, vld}, 32'h0);
      chk("mid_b", {24'd0, b}, 32'h0);
      chk("mid_d", {24'd0, d}, 32'h0);
      chk("mid_ready", {31'd0, ready}, 32'h0);
      step();
      rst_n = 1'b1;
      rdy   = 4'b1111;
      drive(1'b1, 2'd3, 8'h55);
      step();
      chk("post_d", {24'd0, d}, 32'h55);
      chk("post_vld", {28'd0, vld}, 32'h8);
      drive(1'b0, 2'd0, 8'h00);
      step();

`ifdef DEMUX4_CNT_EN
      // Counters: 17 beats to d wraps a 4-bit counter to 1
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 2'd3, 8'(i));
         step();
      end
      drive(1'b0, 2'd0, 8'h00);
      step();
      chk("cnt_a", {28'd0, cnt[0*CNT_W +: CNT_W]}, 32'd0);
      chk("cnt_b", {28'd0, cnt[1*CNT_W +: CNT_W]}, 32'd0);
      chk("cnt_c", {28'd0, cnt[2*CNT_W +: CNT_W]}, 32'd0);
      chk("cnt_d", {28'd0, cnt[3*CNT_W +: CNT_W]}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
